// File: rtl/alu_scheduler.sv
// alu_scheduler: one R-type op per handshake onto shared ALU/shifter/multiplier; out_valid 2 cycles after accept (MULTU: MUL_CYCLES+1).
// Result holds in DONE until out_ready; in_ready only in IDLE. Define ALU_SCHED_MUL_EN to enable MULTU/MFHI/MFLO and HI/LO.
module alu_scheduler #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               err,
  output logic [WIDTH-1:0]   alu_dataA,
  output logic [WIDTH-1:0]   alu_dataB,
  output logic [2:0]         alu_control,
  input  logic [WIDTH-1:0]   alu_sum,
  output logic [WIDTH-1:0]   shf_datain,
  output logic [WIDTH-1:0]   shf_shiftnum,
  input  logic [WIDTH-1:0]   shf_dataout,
  output logic [WIDTH-1:0]   mul_multiplicand,
  output logic [WIDTH-1:0]   mul_multiplier,
  output logic               mul_start,
  input  logic [2*WIDTH-1:0] mul_dataout
);

  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SRL = 6'b000010;

`ifdef ALU_SCHED_MUL_EN
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_mfhi, is_mflo;
`else
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  logic unused_mul_dataout;
  assign unused_mul_dataout = ^mul_dataout;
`endif

  state_t           state_q, state_d;
  logic [5:0]       funct_q, funct_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic             is_alu, is_srl;
  logic [2:0]       alu_ctl;

  always_comb begin
    is_alu  = 1'b1;
    is_srl  = 1'b0;
    alu_ctl = 3'b000;
`ifdef ALU_SCHED_MUL_EN
    is_mfhi = 1'b0;
    is_mflo = 1'b0;
`endif
    case (funct_q)
      F_AND:   alu_ctl = 3'b000;
      F_OR:    alu_ctl = 3'b001;
      F_ADD:   alu_ctl = 3'b010;
      F_SUB:   alu_ctl = 3'b110;
      F_SLT:   alu_ctl = 3'b111;
      F_SRL: begin
        is_alu = 1'b0;
        is_srl = 1'b1;
      end
`ifdef ALU_SCHED_MUL_EN
      F_MFHI: begin
        is_alu  = 1'b0;
        is_mfhi = 1'b1;
      end
      F_MFLO: begin
        is_alu  = 1'b0;
        is_mflo = 1'b1;
      end
`endif
      default: is_alu = 1'b0;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    funct_d          = funct_q;
    a_d              = a_q;
    b_d              = b_q;
    result_d         = result_q;
    err_d            = err_q;
`ifdef ALU_SCHED_MUL_EN
    hi_d             = hi_q;
    lo_d             = lo_q;
    cnt_d            = cnt_q;
`endif
    in_ready         = 1'b0;
    out_valid        = 1'b0;
    alu_dataA        = '0;
    alu_dataB        = '0;
    alu_control      = 3'b000;
    shf_datain       = '0;
    shf_shiftnum     = '0;
    mul_multiplicand = '0;
    mul_multiplier   = '0;
    mul_start        = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          funct_d = funct;
          a_d     = dataA;
          b_d     = dataB;
`ifdef ALU_SCHED_MUL_EN
          if (funct == F_MULTU) begin
            state_d = MUL;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = EXEC;
          end
`else
          state_d = EXEC;
`endif
        end
      end

      EXEC: begin
        state_d  = DONE;
        err_d    = 1'b0;
        result_d = '0;
        if (is_alu) begin
          alu_dataA   = a_q;
          alu_dataB   = b_q;
          alu_control = alu_ctl;
          result_d    = alu_sum;
        end else if (is_srl) begin
          shf_datain   = a_q;
          shf_shiftnum = {{(WIDTH-5){1'b0}}, b_q[4:0]};
          result_d     = shf_dataout;
        end
`ifdef ALU_SCHED_MUL_EN
        else if (is_mfhi) begin
          result_d = hi_q;
        end else if (is_mflo) begin
          result_d = lo_q;
        end
`endif
        else begin
          err_d = 1'b1;
        end
      end

`ifdef ALU_SCHED_MUL_EN
      // Counter is strictly decreasing, so only the first MUL cycle sees CNT_LOAD.
      MUL: begin
        mul_multiplicand = a_q;
        mul_multiplier   = b_q;
        mul_start        = (cnt_q == CNT_LOAD);
        if (cnt_q == '0) begin
          hi_d     = mul_dataout[2*WIDTH-1:WIDTH];
          lo_d     = mul_dataout[WIDTH-1:0];
          result_d = mul_dataout[WIDTH-1:0];
          err_d    = 1'b0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      funct_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
`ifdef ALU_SCHED_MUL_EN
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      funct_q  <= funct_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifdef ALU_SCHED_MUL_EN
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with behavioural ALU, shifter and multi-cycle multiplier models.
module tb_alu_scheduler;

  localparam int MC = 32;
`ifdef ALU_SCHED_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010, F_SLT = 6'b101010, F_SRL = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001, F_MFHI = 6'b010000, F_MFLO = 6'b010010;
  localparam logic [5:0] F_BAD = 6'b111111;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, err, mul_start;
  logic [5:0]  funct;
  logic [31:0] dataA, dataB, result;
  logic [31:0] alu_dataA, alu_dataB, alu_sum;
  logic [2:0]  alu_control;
  logic [31:0] shf_datain, shf_shiftnum, shf_dataout;
  logic [31:0] mul_multiplicand, mul_multiplier;
  logic [63:0] mul_dataout;

  int checks = 0;
  int errors = 0;
  int m_age  = 0;

  alu_scheduler #(.WIDTH(32), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .funct(funct),
    .dataA(dataA), .dataB(dataB),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_control(alu_control), .alu_sum(alu_sum),
    .shf_datain(shf_datain), .shf_shiftnum(shf_shiftnum), .shf_dataout(shf_dataout),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_start(mul_start), .mul_dataout(mul_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_control)
      3'b000:  alu_sum = alu_dataA & alu_dataB;
      3'b001:  alu_sum = alu_dataA | alu_dataB;
      3'b010:  alu_sum = alu_dataA + alu_dataB;
      3'b110:  alu_sum = alu_dataA - alu_dataB;
      3'b111:  alu_sum = {31'b0, $signed(alu_dataA) < $signed(alu_dataB)};
      default: alu_sum = 32'h0;
    endcase
  end

  assign shf_dataout = shf_datain >> shf_shiftnum;

  // Product is only presented in the window MC cycles after the start pulse; junk otherwise.
  always @(posedge clk) begin
    if (mul_start) m_age <= 1;
    else if (m_age != 0 && m_age < 1000) m_age <= m_age + 1;
  end
  assign mul_dataout = (m_age >= MC - 1 && m_age <= MC + 1) ?
                       ({32'b0, mul_multiplicand} * {32'b0, mul_multiplier}) :
                       64'hDEAD_BEEF_0BAD_F00D;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    logic [2:0]  ctl;
    logic [31:0] shn;
    int          lat;
    string       nm;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    int starts;
    bit opbad;
    bit is_mul;
    @(negedge clk);
    chk({v.nm, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    funct    = v.f;
    dataA    = v.a;
    dataB    = v.b;
    @(negedge clk);
    in_valid = 1'b0;
    funct    = F_BAD;
    dataA    = 32'hFFFF_FFFF;
    dataB    = 32'hFFFF_FFFF;
    lat      = 1;
    starts   = 0;
    opbad    = 1'b0;
    is_mul   = MUL_EN && (v.f == F_MULTU);
    chk({v.nm, "_alu_control"}, 64'(alu_control), 64'(v.ctl));
    chk({v.nm, "_shf_shiftnum"}, 64'(shf_shiftnum), 64'(v.shn));
    chk({v.nm, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    while (!out_valid && lat < 200) begin
      if (mul_start) starts++;
      if (is_mul) begin
        if (mul_multiplicand !== v.a || mul_multiplier !== v.b) opbad = 1'b1;
      end else if (mul_multiplicand !== 32'h0 || mul_multiplier !== 32'h0) begin
        opbad = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    chk({v.nm, "_latency"}, 64'(lat), 64'(v.lat));
    chk({v.nm, "_result"}, 64'(result), 64'(v.res));
    chk({v.nm, "_err"}, 64'(err), 64'(v.err));
    chk({v.nm, "_mul_start_count"}, 64'(starts), is_mul ? 64'd1 : 64'd0);
    chk({v.nm, "_mul_operands"}, 64'(opbad), 64'd0);
  endtask

  function automatic vec_t mk(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic e, input logic [2:0] ctl,
                              input logic [31:0] shn, input int lat, input string nm);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.res = res; v.err = e;
    v.ctl = ctl; v.shn = shn; v.lat = lat; v.nm = nm;
    return v;
  endfunction

  initial begin
    int mlat;
    int lat;
    mlat = MUL_EN ? MC + 1 : 2;

    vecs[0]  = mk(F_ADD, 32'd20, 32'd15, 32'd35, 1'b0, 3'b010, 32'd0, 2, "add");
    vecs[1]  = mk(F_SUB, 32'd20, 32'd15, 32'd5,  1'b0, 3'b110, 32'd0, 2, "sub");
    vecs[2]  = mk(F_SLT, 32'd20, 32'd15, 32'd0,  1'b0, 3'b111, 32'd0, 2, "slt_gt");
    vecs[3]  = mk(F_SLT, 32'd15, 32'd20, 32'd1,  1'b0, 3'b111, 32'd0, 2, "slt_lt");
    vecs[4]  = mk(F_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 3'b000, 32'd0, 2, "and");
    vecs[5]  = mk(F_OR,  32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0, 1'b0, 3'b001, 32'd0, 2, "or");
    vecs[6]  = mk(F_SRL, 32'h8000_0000, 32'd33, 32'h4000_0000, 1'b0, 3'b000, 32'd1, 2, "srl");
    vecs[7]  = mk(F_BAD, 32'd20, 32'd15, 32'd0, 1'b1, 3'b000, 32'd0, 2, "illegal");
    vecs[8]  = mk(F_MULTU, 32'd5, 32'd10, MUL_EN ? 32'd50 : 32'd0, !MUL_EN, 3'b000, 32'd0, mlat, "multu_5x10");
    vecs[9]  = mk(F_MFLO, 32'd0, 32'd0, MUL_EN ? 32'd50 : 32'd0, !MUL_EN, 3'b000, 32'd0, 2, "mflo_50");
    vecs[10] = mk(F_MFHI, 32'd0, 32'd0, 32'd0, !MUL_EN, 3'b000, 32'd0, 2, "mfhi_0");
    vecs[11] = mk(F_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_EN ? 32'hFFFF_FFFE : 32'd0, !MUL_EN, 3'b000, 32'd0, mlat, "multu_big");
    vecs[12] = mk(F_MFHI, 32'd0, 32'd0, MUL_EN ? 32'd1 : 32'd0, !MUL_EN, 3'b000, 32'd0, 2, "mfhi_1");
    vecs[13] = mk(F_MFLO, 32'd0, 32'd0, MUL_EN ? 32'hFFFF_FFFE : 32'd0, !MUL_EN, 3'b000, 32'd0, 2, "mflo_big");

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    funct = 6'd0; dataA = 32'd0; dataB = 32'd0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_alu_control", 64'(alu_control), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_op(vecs[i]);

    // Backpressure: result holds and a new request is ignored while DONE is stalled.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; funct = F_ADD; dataA = 32'd20; dataB = 32'd15;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'd2);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; funct = F_SUB; dataA = 32'd100; dataB = 32'd1;
      @(negedge clk);
      chk("bp_result_hold", 64'(result), 64'd35);
      chk("bp_out_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("bp_no_spurious_op", 64'(out_valid), 64'd0);
    chk("bp_result_after", 64'(result), 64'd35);

    // Reset ten cycles into a MULTU (stalled in DONE when the multiplier is absent).
    out_ready = 1'b0;
    in_valid = 1'b1; funct = F_MULTU; dataA = 32'd7; dataB = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_mul_start", 64'(mul_start), 64'd0);
    chk("midrst_mul_multiplicand", 64'(mul_multiplicand), 64'd0);
    chk("midrst_mul_multiplier", 64'(mul_multiplier), 64'd0);
    chk("midrst_alu_dataA", 64'(alu_dataA), 64'd0);
    chk("midrst_shf_datain", 64'(shf_datain), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    run_op(mk(F_MFLO, 32'd0, 32'd0, 32'd0, !MUL_EN, 3'b000, 32'd0, 2, "mflo_after_rst"));
    run_op(mk(F_MULTU, 32'd3, 32'd4, MUL_EN ? 32'd12 : 32'd0, !MUL_EN, 3'b000, 32'd0, mlat, "multu_3x4"));
    run_op(mk(F_MFHI, 32'd0, 32'd0, 32'd0, !MUL_EN, 3'b000, 32'd0, 2, "mfhi_after_3x4"));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
